// File: rtl/sram_arb_pkg.sv
// Shared types and width helpers for the single-port SRAM arbiter.
package sram_arb_pkg;

  // Index width for n items, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned be_width(input int unsigned data_width);
    return (data_width + 7) / 8;
  endfunction

  localparam int unsigned DefDataWidth = 64;
  localparam int unsigned DefNumWords  = 1024;
  localparam int unsigned DefAw        = idx_width(DefNumWords);
  localparam int unsigned DefBw        = be_width(DefDataWidth);

  typedef struct packed {
    logic                    we;
    logic [DefAw-1:0]        addr;
    logic [DefDataWidth-1:0] wdata;
    logic [DefBw-1:0]        be;
  } sram_req_t;

endpackage

// File: rtl/sram_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic found;

  // Two passes: indices from ptr_i upward, then the wrapped indices below ptr_i.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && req_i[j] && (j >= 32'(ptr_i))) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && req_i[j] && (j < 32'(ptr_i))) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin sharing of one single-port SRAM between N_PORTS requesters.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned N_PORTS    = 2,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_WORDS  = 1024,
  localparam int unsigned AW = idx_width(NUM_WORDS),
  localparam int unsigned BW = be_width(DATA_WIDTH)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [N_PORTS-1:0]                  req_valid_i,
  output logic [N_PORTS-1:0]                  req_ready_o,
  input  logic [N_PORTS-1:0]                  req_we_i,
  input  logic [N_PORTS-1:0][AW-1:0]          req_addr_i,
  input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata_i,
  input  logic [N_PORTS-1:0][BW-1:0]          req_be_i,
  output logic [N_PORTS-1:0]                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0]               rsp_rdata_o,
  output logic                                sram_req_o,
  output logic                                sram_we_o,
  output logic [AW-1:0]                       sram_addr_o,
  output logic [DATA_WIDTH-1:0]               sram_wdata_o,
  output logic [BW-1:0]                       sram_be_o,
  input  logic [DATA_WIDTH-1:0]               sram_rdata_i
);

  localparam int unsigned PW = idx_width(N_PORTS);

  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               rsp_pending_q, rsp_pending_d;
  logic [PW-1:0]      rsp_port_q, rsp_port_d;
  logic               rsp_is_read_q, rsp_is_read_d;

  logic [N_PORTS-1:0] gnt;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_any;

  rr_arbiter #(
    .N (N_PORTS)
  ) u_rr_arbiter (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign req_ready_o = gnt;

  always_comb begin
    sram_req_o   = gnt_any;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (gnt_any) begin
      sram_we_o   = req_we_i[gnt_idx];
      sram_addr_o = req_addr_i[gnt_idx];
      // Reads fetch the full word; write data is irrelevant and kept quiet.
      if (req_we_i[gnt_idx]) begin
        sram_wdata_o = req_wdata_i[gnt_idx];
        sram_be_o    = req_be_i[gnt_idx];
      end else begin
        sram_be_o    = '1;
      end
    end
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    rsp_pending_d = gnt_any;
    rsp_port_d    = gnt_idx;
    rsp_is_read_d = gnt_any & ~req_we_i[gnt_idx];
    if (gnt_any) begin
      if (gnt_idx == PW'(N_PORTS - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q      <= '0;
      rsp_pending_q <= 1'b0;
      rsp_port_q    <= '0;
      rsp_is_read_q <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_port_q    <= rsp_port_d;
      rsp_is_read_q <= rsp_is_read_d;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (rsp_pending_q) begin
      rsp_valid_o[rsp_port_q] = 1'b1;
    end
    rsp_rdata_o = (rsp_pending_q && rsp_is_read_q) ? sram_rdata_i : '0;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural SRAM and a reference model.
module tb_sram_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int NW = 256;
  localparam int AW = 8;
  localparam int BW = 8;

  typedef struct {
    int          port;
    logic [63:0] data;
    longint      due;
  } exp_t;

  logic                    clk;
  logic                    rst_ni;
  logic [NP-1:0]           valid;
  logic [NP-1:0]           req_ready;
  logic [NP-1:0]           we;
  logic [NP-1:0][AW-1:0]   addr;
  logic [NP-1:0][DW-1:0]   wdata;
  logic [NP-1:0][BW-1:0]   be;
  logic [NP-1:0]           rsp_valid;
  logic [DW-1:0]           rsp_rdata;
  logic                    sram_req;
  logic                    sram_we;
  logic [AW-1:0]           sram_addr;
  logic [DW-1:0]           sram_wdata;
  logic [BW-1:0]           sram_be;
  logic [DW-1:0]           sram_rdata;

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  bit          started = 0;
  int          ref_ptr = 0;
  logic [63:0] ref_mem [NW];
  logic [63:0] mem [NW];
  logic [63:0] last_rdata [NP];
  exp_t        sb_q [$];

  sram_arbiter #(
    .N_PORTS    (NP),
    .DATA_WIDTH (DW),
    .NUM_WORDS  (NW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (valid),
    .req_ready_o  (req_ready),
    .req_we_i     (we),
    .req_addr_i   (addr),
    .req_wdata_i  (wdata),
    .req_be_i     (be),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_be_o    (sram_be),
    .sram_rdata_i (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port SRAM with registered read data.
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < BW; b++) begin
          if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
        end
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: first valid port scanning from ref_ptr with modulo wrap.
  task automatic check_grant();
    int          g;
    int          p;
    logic [NP-1:0] exp_rdy;
    logic [80:0] exp_drv;
    exp_t        e;
    g = -1;
    for (int k = 0; k < NP; k++) begin
      p = (ref_ptr + k) % NP;
      if (g < 0 && valid[p]) g = p;
    end
    exp_rdy = '0;
    exp_drv = '0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      exp_drv = {we[g], addr[g], (we[g] ? wdata[g] : {DW{1'b0}}),
                 (we[g] ? be[g] : {BW{1'b1}})};
    end
    chk("req_ready", 128'(req_ready), 128'(exp_rdy));
    chk("sram_req", 128'(sram_req), 128'(g >= 0));
    chk("sram_drive", 128'({sram_we, sram_addr, sram_wdata, sram_be}), 128'(exp_drv));
    if (g >= 0) begin
      e.port = g;
      e.due  = cyc + 1;
      if (we[g]) begin
        for (int b = 0; b < BW; b++) begin
          if (be[g][b]) ref_mem[addr[g]][b*8 +: 8] = wdata[g][b*8 +: 8];
        end
        e.data = '0;
      end else begin
        e.data = ref_mem[addr[g]];
      end
      sb_q.push_back(e);
      ref_ptr = (g + 1) % NP;
    end
  endtask

  always @(negedge clk) begin
    if (rst_ni && started) check_grant();
  end

  // Response monitor.
  always @(negedge clk) begin
    exp_t          e;
    logic [NP-1:0] exp_v;
    if (!rst_ni) begin
      chk("rsp_valid_in_reset", 128'(rsp_valid), 128'(0));
    end else if (rsp_valid != '0) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual=%0h required=0", rsp_valid);
      end else begin
        e = sb_q.pop_front();
        exp_v = '0;
        exp_v[e.port] = 1'b1;
        chk("rsp_port", 128'(rsp_valid), 128'(exp_v));
        chk("rsp_rdata", 128'(rsp_rdata), 128'(e.data));
        chk("rsp_latency", 128'(cyc), 128'(e.due));
        last_rdata[e.port] = rsp_rdata;
      end
    end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL rsp_missing actual=none required=port%0d", sb_q[0].port);
      void'(sb_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input bit w, input int a, input logic [63:0] d,
                          input logic [7:0] b);
    valid[p] = 1'b1;
    we[p]    = w;
    addr[p]  = AW'(a);
    wdata[p] = d;
    be[p]    = b;
  endtask

  task automatic clear_all();
    valid = '0;
    we    = '0;
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < NP; i++) last_rdata[i] = '0;
    sram_rdata = '0;
    rst_ni = 1'b0;
    valid  = '0;
    we     = '0;
    addr   = '0;
    wdata  = '0;
    be     = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 128'(req_ready), 128'(0));
    chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("reset_rsp_rdata", 128'(rsp_rdata), 128'(0));
    chk("reset_sram", 128'({sram_req, sram_we, sram_addr, sram_wdata, sram_be}), 128'(0));
    rst_ni  = 1'b1;
    started = 1'b1;
    tick();
    tick();

    // All ports valid straight after reset: port 0 must win.
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, p, '0, '0);
    tick();
    clear_all();

    // Port 0 writes 0x10, port 1 reads it back on the next cycle.
    tick();
    set_port(0, 1'b1, 'h10, 64'hDEADBEEF_01234567, 8'hFF);
    tick();
    clear_all();
    set_port(1, 1'b0, 'h10, '0, '0);
    tick();
    clear_all();
    tick();
    chk("raw_rdata_port1", 128'(last_rdata[1]), 128'(64'hDEADBEEF_01234567));

    // Ports 0 and 1 contend for six cycles.
    for (int i = 0; i < 6; i++) begin
      set_port(0, 1'b0, 'h10, '0, '0);
      set_port(1, 1'b0, $urandom_range(0, 15), '0, '0);
      tick();
    end
    clear_all();

    // Pointer now at 2: ports 1 and 3 contend, 3 first then 1.
    set_port(1, 1'b0, 3, '0, '0);
    set_port(3, 1'b0, 4, '0, '0);
    tick();
    tick();
    clear_all();

    // Partial write keeps the upper bytes of the old word.
    tick();
    set_port(2, 1'b1, 'h20, 64'h11111111_22222222, 8'hFF);
    tick();
    set_port(2, 1'b1, 'h20, 64'hFFFFFFFF_AAAAAAAA, 8'h0F);
    tick();
    set_port(2, 1'b0, 'h20, '0, '0);
    tick();
    clear_all();
    tick();
    chk("partial_rdata_port2", 128'(last_rdata[2]), 128'(64'h11111111_AAAAAAAA));

    // Randomized traffic over a small address window to provoke read-after-write.
    for (int i = 0; i < 300; i++) begin
      for (int p = 0; p < NP; p++) begin
        valid[p] = ($urandom_range(0, 99) < 60);
        we[p]    = $urandom_range(0, 1) == 1;
        addr[p]  = AW'($urandom_range(0, 15));
        wdata[p] = {$urandom, $urandom};
        be[p]    = BW'($urandom_range(0, 255));
      end
      tick();
    end
    clear_all();
    tick();
    tick();

    // Reset while a read response is on the bus.
    set_port(2, 1'b0, 5, '0, '0);
    tick();
    clear_all();
    chk("pre_reset_rsp", 128'(rsp_valid), 128'(4'b0100));
    rst_ni = 1'b0;
    sb_q.delete();
    ref_ptr = 0;
    #1;
    chk("reset_drops_rsp", 128'(rsp_valid), 128'(0));
    chk("reset_drops_rdata", 128'(rsp_rdata), 128'(0));
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, p + 8, '0, '0);
    #1;
    chk("post_reset_grant", 128'(req_ready), 128'(4'b0001));
    tick();
    clear_all();
    repeat (3) tick();
    chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
